button_conditioner: RTL and testbench

- Input-side companion to the board's divider/counter output path. Conditions raw push-button inputs into clean, single-cycle control strobes (enable, reset request) for downstream counters.
- Per channel, the block:
  - synchronises the raw input;
  - debounces it on a shared slow sampling tick from an internal prescaler;
  - emits press and release pulses, plus auto-repeat pulses while the button is held.

---
 rtl/button_conditioner_if.sv | 34 +++
 rtl/button_conditioner.sv | 165 ++++++++++++++++
 tb/tb_button_conditioner.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/button_conditioner_if.sv
// Button conditioner bus: raw button inputs in, conditioned levels and
// single-cycle strobes out, plus the shared sampling tick.
// "release" and "repeat" are SystemVerilog keywords, so those strobes
// carry a _pulse suffix.
interface button_conditioner_if #(
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0] btn_in;
    logic [CHANNELS-1:0] level;
    logic [CHANNELS-1:0] press;
    logic [CHANNELS-1:0] release_pulse;
    logic [CHANNELS-1:0] repeat_pulse;
    logic                tick;

    // The side that owns the buttons and consumes the strobes
    modport master (
        output btn_in,
        input  level,
        input  press,
        input  release_pulse,
        input  repeat_pulse,
        input  tick
    );

    // The conditioner itself
    modport slave (
        input  btn_in,
        output level,
        output press,
        output release_pulse,
        output repeat_pulse,
        output tick
    );
endinterface

// File: rtl/button_conditioner.sv
// Push-button conditioner: per channel, synchronise the raw input, debounce
// it on a shared slow tick and turn accepted level changes into press /
// release strobes, plus auto-repeat strobes while the button stays held.
module button_conditioner #(
    parameter int CHANNELS     = 2,
    parameter int DIV_BITS     = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int STABLE_TICKS = 4,
    parameter int REPEAT_DELAY = 64,
    parameter int REPEAT_RATE  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    button_conditioner_if.slave   bus
);

    localparam int SW   = $clog2(STABLE_TICKS + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX + 1);

    // Terminal counts: the value that, once incremented, would hit the threshold
    localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_TICKS - 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        HELD      = 2'd1,
        REPEATING = 2'd2
    } chan_state_t;

    logic [DIV_BITS-1:0] prescaler;
    logic                tick;

    // Free-running prescaler; the tick is its all-ones state
    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
        end
    end

    assign tick     = &prescaler;
    assign bus.tick = tick;

    for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
        logic [SYNC_STAGES-1:0] sync_ff;
        logic                   sync_s;
        logic [SW-1:0]          stab_cnt;
        logic [SW-1:0]          stab_cnt_next;
        logic                   accept;
        logic                   level_r;
        logic                   press_r;
        logic                   release_r;
        logic                   repeat_r;
        chan_state_t            state;
        chan_state_t            state_next;
        logic [RW-1:0]          rpt_cnt;
        logic [RW-1:0]          rpt_cnt_next;
        logic                   repeat_set;

        // Shift the raw button through the synchroniser chain
        always_ff @(posedge clk) begin
            if (rst) begin
                sync_ff <= '0;
            end else begin
                sync_ff <= {sync_ff[SYNC_STAGES-2:0], bus.btn_in[ch]};
            end
        end

        assign sync_s = sync_ff[SYNC_STAGES-1];

        // Debounce: count consecutive ticks that disagree with the level
        always_comb begin
            stab_cnt_next = stab_cnt;
            accept        = 1'b0;
            if (tick) begin
                if (sync_s != level_r) begin
                    if (stab_cnt == STAB_LAST) begin
                        stab_cnt_next = '0;
                        accept        = 1'b1;
                    end else begin
                        stab_cnt_next = stab_cnt + 1'b1;
                    end
                end else begin
                    stab_cnt_next = '0;
                end
            end
        end

        // Channel FSM: a release wins over a repeat threshold on the same tick
        always_comb begin
            state_next   = state;
            rpt_cnt_next = rpt_cnt;
            repeat_set   = 1'b0;
            case (state)
                IDLE: begin
                    if (accept && !level_r) begin
                        state_next   = HELD;
                        rpt_cnt_next = '0;
                    end
                end
                HELD: begin
                    if (accept && level_r) begin
                        state_next   = IDLE;
                        rpt_cnt_next = '0;
                    end else if (tick) begin
                        if (rpt_cnt == DELAY_LAST) begin
                            state_next   = REPEATING;
                            rpt_cnt_next = '0;
                            repeat_set   = 1'b1;
                        end else begin
                            rpt_cnt_next = rpt_cnt + 1'b1;
                        end
                    end
                end
                REPEATING: begin
                    if (accept && level_r) begin
                        state_next   = IDLE;
                        rpt_cnt_next = '0;
                    end else if (tick) begin
                        if (rpt_cnt == RATE_LAST) begin
                            rpt_cnt_next = '0;
                            repeat_set   = 1'b1;
                        end else begin
                            rpt_cnt_next = rpt_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state_next   = IDLE;
                    rpt_cnt_next = '0;
                end
            endcase
        end

        // Register level, strobes, counters and FSM state together
        always_ff @(posedge clk) begin
            if (rst) begin
                stab_cnt  <= '0;
                level_r   <= 1'b0;
                press_r   <= 1'b0;
                release_r <= 1'b0;
                repeat_r  <= 1'b0;
                state     <= IDLE;
                rpt_cnt   <= '0;
            end else begin
                stab_cnt  <= stab_cnt_next;
                level_r   <= level_r ^ accept;
                press_r   <= accept & ~level_r;
                release_r <= accept & level_r;
                repeat_r  <= repeat_set;
                state     <= state_next;
                rpt_cnt   <= rpt_cnt_next;
            end
        end

        assign bus.level[ch]         = level_r;
        assign bus.press[ch]         = press_r;
        assign bus.release_pulse[ch] = release_r;
        assign bus.repeat_pulse[ch]  = repeat_r;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios with spot
// checks on event timing, then random button activity, all compared every
// cycle against a tick-counting reference model.
module tb_button_conditioner;

    localparam int CH       = 2;
    localparam int DIV_BITS = 2;
    localparam int SYNC     = 2;
    localparam int STABLE   = 4;
    localparam int DELAY    = 8;
    localparam int RATE     = 4;
    localparam int PERIOD   = 1 << DIV_BITS;

    logic clk = 1'b0;
    logic rst;

    button_conditioner_if #(.CHANNELS(CH)) bus ();

    button_conditioner #(
        .CHANNELS     (CH),
        .DIV_BITS     (DIV_BITS),
        .SYNC_STAGES  (SYNC),
        .STABLE_TICKS (STABLE),
        .REPEAT_DELAY (DELAY),
        .REPEAT_RATE  (RATE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 10 time-unit clock
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state: cycles since reset, delayed button history,
    // per-channel run of disagreeing ticks and ticks held since press
    int              mCyc;
    logic [CH-1:0]   mHist[$];
    int              mRun[CH];
    int              mHeld[CH];
    logic [CH-1:0]   expLevel;
    logic [CH-1:0]   expPress;
    logic [CH-1:0]   expRel;
    logic [CH-1:0]   expRep;
    logic            expTick;

    // Directed capture of event timing (channel 0), in cycles since reset release
    int  tbCyc;
    bit  lastRst;
    bit  curRst;
    int  firstTick;
    int  firstPress;
    int  rep1;
    int  rep2;
    int  firstRel;
    int  repAfterRel;
    int  ch1Activity;
    int  levelSeen;

    task automatic modelStep(input logic [CH-1:0] b, input logic r);
        logic [CH-1:0] s;
        bit            isTick;
        bit            accepted;
        if (r) begin
            mCyc = 0;
            mHist.delete();
            for (int i = 0; i < SYNC; i++) mHist.push_back('0);
            for (int c = 0; c < CH; c++) begin
                mRun[c]  = 0;
                mHeld[c] = 0;
            end
            expLevel = '0;
            expPress = '0;
            expRel   = '0;
            expRep   = '0;
            expTick  = 1'b0;
        end else begin
            isTick   = (mCyc % PERIOD) == PERIOD - 1;
            s        = mHist.pop_front();
            mHist.push_back(b);
            expPress = '0;
            expRel   = '0;
            expRep   = '0;
            for (int c = 0; c < CH; c++) begin
                if (isTick) begin
                    accepted = 1'b0;
                    if (s[c] != expLevel[c]) begin
                        mRun[c]++;
                        if (mRun[c] == STABLE) begin
                            mRun[c]  = 0;
                            accepted = 1'b1;
                        end
                    end else begin
                        mRun[c] = 0;
                    end
                    if (accepted && !expLevel[c]) begin
                        expLevel[c] = 1'b1;
                        expPress[c] = 1'b1;
                        mHeld[c]    = 0;
                    end else if (accepted) begin
                        expLevel[c] = 1'b0;
                        expRel[c]   = 1'b1;
                    end else if (expLevel[c]) begin
                        mHeld[c]++;
                        if (mHeld[c] == DELAY ||
                            (mHeld[c] > DELAY && ((mHeld[c] - DELAY) % RATE) == 0))
                            expRep[c] = 1'b1;
                    end
                end
            end
            mCyc++;
            expTick = (mCyc % PERIOD) == PERIOD - 1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, tbCyc);
        end
    endtask

    task automatic clearCapture();
        firstTick   = -1;
        firstPress  = -1;
        rep1        = -1;
        rep2        = -1;
        firstRel    = -1;
        repAfterRel = 0;
        ch1Activity = 0;
        levelSeen   = 0;
    endtask

    task automatic checkCycle();
        checkOutput("level",   32'(bus.level),         32'(expLevel));
        checkOutput("press",   32'(bus.press),         32'(expPress));
        checkOutput("release", 32'(bus.release_pulse), 32'(expRel));
        checkOutput("repeat",  32'(bus.repeat_pulse),  32'(expRep));
        checkOutput("tick",    32'(bus.tick),          32'(expTick));
        if (!curRst) begin
            if (bus.tick === 1'b1 && firstTick < 0) firstTick = tbCyc;
            if (bus.press[0] === 1'b1 && firstPress < 0) firstPress = tbCyc;
            if (bus.level[0] === 1'b1) levelSeen++;
            if (bus.release_pulse[0] === 1'b1 && firstRel < 0) firstRel = tbCyc;
            if (bus.repeat_pulse[0] === 1'b1) begin
                if (firstRel >= 0) repAfterRel++;
                else if (rep1 < 0) rep1 = tbCyc;
                else if (rep2 < 0) rep2 = tbCyc;
            end
            if (bus.level[1] !== 1'b0 || bus.press[1] !== 1'b0 ||
                bus.release_pulse[1] !== 1'b0 || bus.repeat_pulse[1] !== 1'b0)
                ch1Activity++;
        end
    endtask

    // Drive one input pattern for n cycles, checking outputs each cycle
    task automatic applyStimulus(input logic [CH-1:0] b, input logic r, input int n);
        for (int i = 0; i < n; i++) begin
            bus.btn_in = b;
            rst        = r;
            curRst     = r;
            if (lastRst) tbCyc = 0;
            else tbCyc++;
            lastRst = r;
            @(negedge clk);
            checkCycle();
            @(posedge clk);
            modelStep(b, r);
            #1;
        end
    endtask

    initial begin
        bus.btn_in = '0;
        rst        = 1'b1;
        lastRst    = 1'b1;
        curRst     = 1'b1;
        tbCyc      = 0;
        @(posedge clk);
        modelStep('0, 1'b1);
        #1;

        $display("[TB] reset and idle");
        clearCapture();
        applyStimulus(2'b11, 1'b1, 5);
        applyStimulus(2'b00, 1'b0, 12);
        checkOutput("first_tick_cycle", 32'(firstTick), 32'd3);

        $display("[TB] clean press");
        clearCapture();
        applyStimulus(2'b00, 1'b1, 1);
        applyStimulus(2'b01, 1'b0, 30);
        checkOutput("press_cycle", 32'(firstPress), 32'd16);
        checkOutput("ch1_quiet", 32'(ch1Activity), 32'd0);

        $display("[TB] glitch rejection");
        clearCapture();
        applyStimulus(2'b00, 1'b1, 1);
        applyStimulus(2'b01, 1'b0, 10);
        applyStimulus(2'b00, 1'b0, 30);
        checkOutput("glitch_press", 32'(firstPress), 32'hFFFF_FFFF);
        checkOutput("glitch_level", 32'(levelSeen), 32'd0);

        $display("[TB] auto-repeat then reset mid-hold");
        clearCapture();
        applyStimulus(2'b00, 1'b1, 1);
        applyStimulus(2'b01, 1'b0, 90);
        checkOutput("repeat_press", 32'(firstPress), 32'd16);
        checkOutput("repeat_first", 32'(rep1), 32'd48);
        checkOutput("repeat_second", 32'(rep2), 32'd64);
        clearCapture();
        applyStimulus(2'b01, 1'b1, 1);
        applyStimulus(2'b01, 1'b0, 25);
        checkOutput("rst_hold_press", 32'(firstPress), 32'd16);
        checkOutput("rst_hold_release", 32'(firstRel), 32'hFFFF_FFFF);

        $display("[TB] release coinciding with repeat threshold");
        clearCapture();
        applyStimulus(2'b00, 1'b1, 1);
        applyStimulus(2'b01, 1'b0, 48);
        applyStimulus(2'b00, 1'b0, 40);
        checkOutput("prio_repeat", 32'(rep1), 32'd48);
        checkOutput("prio_release", 32'(firstRel), 32'd64);
        checkOutput("prio_no_repeat", 32'(repAfterRel), 32'd0);

        $display("[TB] random activity");
        for (int seg = 0; seg < 150; seg++) begin
            if ($urandom_range(0, 24) == 0)
                applyStimulus(CH'($urandom_range(0, 3)), 1'b1, $urandom_range(1, 2));
            else if ($urandom_range(0, 5) == 0)
                applyStimulus(CH'($urandom_range(0, 3)), 1'b0, $urandom_range(60, 160));
            else
                applyStimulus(CH'($urandom_range(0, 3)), 1'b0, $urandom_range(1, 40));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
